// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine with its own HI/LO result registers.
// MULT/MULTU use shift-add; DIV/DIVU use restoring shift-subtract. Both work on
// operand magnitudes, and the sign is corrected in FIX. Divide-by-zero also
// passes through FIX, without loading hi/lo, so its done pulse comes two edges
// after start.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t               state, state_nxt;
   logic [1:0]           op_r;
   logic [WIDTH-1:0]     a_r;
   logic [WIDTH-1:0]     b_r;    // raw b; after PREP, multiplicand or divisor magnitude
   logic [2*WIDTH-1:0]   acc;    // mult: {partial product, multiplier}; div: low half = quotient
   logic [WIDTH-1:0]     rem;
   logic [CNT_W-1:0]     cnt;
   logic                 neg_q;  // product / quotient must be negated
   logic                 neg_r;  // remainder must be negated

   logic                 is_div, is_signed, zero_div;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       part;   // shifted partial remainder, one bit wider than rem
   logic                 ge;
   logic [WIDTH-1:0]     diff;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign is_div    = op_r[1];
   assign is_signed = ~op_r[0];
   assign zero_div  = is_div && (b_r == '0);
   assign abs_a     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
   assign abs_b     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;

   // Shift-add step: add the multiplicand into the upper half when the multiplier LSB is set.
   assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);

   // Restoring step: bring in the next dividend bit and subtract if the divisor fits.
   // When it fits, the true difference is below the divisor, so WIDTH bits hold it.
   assign part     = {rem, acc[WIDTH-1]};
   assign ge       = part >= {1'b0, b_r};
   assign diff     = part[WIDTH-1:0] - b_r;

   assign prod_fix = neg_q ? -acc : acc;
   assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_r ? -rem : rem;

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PREP;
         PREP:    state_nxt = zero_div ? FIX : CALC;
         CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, magnitude prep, iteration, sign fix and result load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         rem      <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_r     <= op;
               a_r      <= a;
               b_r      <= b;
               div_zero <= 1'b0;
            end
            PREP: begin
               neg_q <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               neg_r <= is_signed & a_r[WIDTH-1];
               cnt   <= CNT_W'(WIDTH);
               rem   <= '0;
               if (is_div) begin
                  acc <= {{WIDTH{1'b0}}, abs_a};
                  b_r <= abs_b;
               end else begin
                  acc <= {{WIDTH{1'b0}}, abs_b};
                  b_r <= abs_a;
               end
            end
            CALC: begin
               cnt <= cnt - CNT_W'(1);
               if (is_div) begin
                  rem             <= ge ? diff : part[WIDTH-1:0];
                  acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], ge};
               end else begin
                  acc <= {add_sum, acc[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (zero_div) begin
                  div_zero <= 1'b1;
               end else if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit. The reference model uses plain
// 64-bit arithmetic. A monitor checks every done pulse against the queue.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = '0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Edge counter used for latency checks.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   int           n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Reference model: updates the model HI/LO and reports divide-by-zero.
   task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic dz);
      longint      sx = longint'($signed(x));
      longint      sy = longint'($signed(y));
      logic [63:0] p;
      dz = 1'b0;
      case (o)
         2'b00: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
         2'b01: begin p = 64'(x) * 64'(y); m_hi = p[63:32]; m_lo = p[31:0]; end
         2'b10: if (y == '0) dz = 1'b1;
                else begin m_lo = W'(sx / sy); m_hi = W'(sx % sy); end
         default: if (y == '0) dz = 1'b1;
                else begin m_lo = x / y; m_hi = x % y; end
      endcase
   endtask

   // Monitor: compares every done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (reset && done) begin
         if (sb.size() == 0) fail_now("unexpected_done");
         else begin
            mon_e = sb.pop_front();
            chk("hi", hi, mon_e.hi);
            chk("lo", lo, mon_e.lo);
            chk("div_zero", div_zero, mon_e.dz);
            chk("latency", cyc, mon_e.cyc);
         end
      end
   end

   // Issue one op at a negedge, wait for done, and return one negedge after done.
   // poke_busy pulses a second start during the op. poke_done raises start in the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit poke_busy, input bit poke_done);
      exp_t e;
      logic dz;
      bit   seen = 0;
      model(o, x, y, dz);
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.dz  = dz;
      e.cyc = cyc + 1 + (dz ? 2 : W + 2);
      sb.push_back(e);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      for (int k = 0; k < 3 * W; k++) begin
         if (done) begin seen = 1; break; end
         chk("busy_during_op", busy, 1);
         if (poke_busy && k == 4) start = 1'b1;
         if (poke_busy && k == 5) start = 1'b0;
         @(negedge clk);
      end
      if (!seen) begin
         fail_now("done_timeout");
         sb.delete();
      end
      if (poke_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done", busy, 0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   // Stimulus sequence.
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      reset = 1'b1;
      @(negedge clk);

      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, 1);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFF1);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      chk("divovf_lo", lo, 32'h8000_0000);
      chk("divovf_hi", hi, 32'h0);
      chk("divovf_dz", div_zero, 0);
      run_op(2'b11, 32'h5, 32'h2, 0, 0);
      run_op(2'b11, 32'h10, 32'h0, 0, 0);
      chk("dz_hi_kept", hi, 32'h1);
      chk("dz_lo_kept", lo, 32'h2);
      repeat (3) @(negedge clk);
      chk("dz_held", div_zero, 1);
      run_op(2'b01, 32'h3, 32'h4, 1, 0);
      chk("dz_cleared", div_zero, 0);
      repeat (W + 6) @(negedge clk);
      chk("busy_start_ignored", busy, 0);

      // Abandon a MULT with reset after a start pulse that arrives while it is busy.
      op = 2'b00; a = $urandom; b = $urandom; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_dz", div_zero, 0);
      run_op(2'b11, 32'd100, 32'd7, 0, 0);
      chk("divu_lo", lo, 32'hE);
      chk("divu_hi", hi, 32'h2);

      for (int i = 0; i < 60; i++)
         run_op(2'($urandom), pick(), pick(), 0, 0);

      repeat (4) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #1ms;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
